// File: rtl/wb_alu_array.sv
// Wishbone-slave ALU peripheral: eight ops, configurable width and latency, done interrupt.
// Optional feature macro ALU_ACCUM_EN: CTRL[5] ACC chains from RESULT instead of OPA.
module wb_alu_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              irq_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [2:0]        op;
    logic              irq_en;
    logic              acc;
    logic              done;
    logic              carry;
    logic              wr_err;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] p_a;
    logic [DATA_W-1:0] p_b;
    logic [2:0]        p_op;

    logic [7:0]        off;
    logic              hit;
    logic              wr;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_opa;
    logic              wr_opb;
    logic              start_ok;
    logic              err_set;
    logic              acc_eff;
    logic [31:0]       wmask;
    logic [31:0]       rdata;
    logic [DATA_W-1:0] opa_merged;
    logic [DATA_W-1:0] opb_merged;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [31:0]       shamt;

    assign off       = wbs_adr_i[7:0];
    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Writes commit while the master still holds the request during the ack cycle.
    assign wr        = wbs_ack_o & wbs_cyc_i & wbs_stb_i & wbs_we_i;
    assign wr_ctrl   = wr & (off == 8'h00);
    assign wr_status = wr & (off == 8'h04);
    assign wr_opa    = wr & (off == 8'h08);
    assign wr_opb    = wr & (off == 8'h0C);
    assign start_ok  = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0] & ~busy_o;
    assign err_set   = busy_o & ((wr_ctrl & wbs_sel_i[0]) | wr_opa | wr_opb);

`ifdef ALU_ACCUM_EN
    assign acc_eff = wbs_dat_i[5];
`else
    assign acc_eff = 1'b0;
    assign acc     = 1'b0;
`endif

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{wbs_sel_i[i]}};
        end
    end

    assign opa_merged = (opa & ~wmask[DATA_W-1:0]) | (wbs_dat_i[DATA_W-1:0] & wmask[DATA_W-1:0]);
    assign opb_merged = (opb & ~wmask[DATA_W-1:0]) | (wbs_dat_i[DATA_W-1:0] & wmask[DATA_W-1:0]);

    always_comb begin
        rdata = '0;
        case (off)
            8'h00:   rdata = {26'b0, acc, irq_en, op, 1'b0};
            8'h04:   rdata = {28'b0, wr_err, carry, done, busy_o};
            8'h08:   rdata = 32'(opa);
            8'h0C:   rdata = 32'(opb);
            8'h10:   rdata = 32'(result_o);
            default: rdata = '0;
        endcase
    end

    always_comb begin
        sum       = {1'b0, p_a} + {1'b0, p_b};
        diff      = {1'b0, p_a} - {1'b0, p_b};
        shamt     = {27'b0, p_b[4:0]};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (p_op)
            3'd0: alu_res = p_a ^ p_b;
            3'd1: alu_res = p_a & p_b;
            3'd2: alu_res = p_a | p_b;
            3'd3: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            3'd4: begin
                alu_res   = diff[DATA_W-1:0];
                alu_carry = diff[DATA_W];
            end
            3'd5: alu_res = ~(p_a ^ p_b);
            3'd6: alu_res = (shamt >= DATA_W) ? '0 : (p_a << p_b[4:0]);
            3'd7: alu_res = (shamt >= DATA_W) ? '0 : (p_a >> p_b[4:0]);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            carry     <= 1'b0;
            wr_err    <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            p_a       <= '0;
            p_b       <= '0;
            p_op      <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            irq_o     <= 1'b0;
            busy_o    <= 1'b0;
            result_o  <= '0;
`ifdef ALU_ACCUM_EN
            acc       <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= hit & ~wbs_ack_o;
            wbs_dat_o <= (hit & ~wbs_ack_o) ? rdata : '0;
            irq_o     <= done & irq_en;

            if (err_set) begin
                wr_err <= 1'b1;
            end else if (wr_status & wbs_sel_i[0] & wbs_dat_i[3]) begin
                wr_err <= 1'b0;
            end

            if (wr_ctrl & wbs_sel_i[0]) begin
                irq_en <= wbs_dat_i[4];
`ifdef ALU_ACCUM_EN
                acc    <= wbs_dat_i[5];
`endif
                if (!busy_o) begin
                    op <= wbs_dat_i[3:1];
                end
            end
            if (wr_opa & ~busy_o) begin
                opa <= opa_merged;
            end
            if (wr_opb & ~busy_o) begin
                opb <= opb_merged;
            end

            // The W1C is overridden below by start (clear) or completion (set).
            if (wr_status & wbs_sel_i[0] & wbs_dat_i[1]) begin
                done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        cnt    <= 4'(PIPE_STAGES - 1);
                        busy_o <= 1'b1;
                        done   <= 1'b0;
                        p_a    <= acc_eff ? result_o : opa;
                        p_b    <= opb;
                        p_op   <= wbs_dat_i[3:1];
                    end
                end
                RUN: begin
                    if (cnt == 4'd0) begin
                        state    <= DONE_ST;
                        result_o <= alu_res;
                        carry    <= alu_carry;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE_ST: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
